// File: rtl/upsizing_pkg.sv
// Shared types and constants for the 2:1 stream upsizer.
package upsizing_pkg;

    typedef enum logic {
        PH_UPPER = 1'b0,
        PH_LOWER = 1'b1
    } phase_e;

    localparam logic [1:0] KEEP_FULL  = 2'b11;
    localparam logic [1:0] KEEP_UPPER = 2'b10;

endpackage

// File: rtl/upsizing.sv
// Packs pairs of W-bit stream beats into one 2W-bit word, first beat in the upper half.
// Define UPSIZING_TLAST_EN to add in_tlast/out_tkeep/out_tlast packet framing.
module upsizing
    import upsizing_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [W-1:0]   in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
`ifdef UPSIZING_TLAST_EN
    input  logic           in_tlast,
    output logic [1:0]     out_tkeep,
    output logic           out_tlast,
`endif
    output logic [2*W-1:0] out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready
);

    phase_e         phase_q, phase_d;
    logic [W-1:0]   hold_q, hold_d;
    logic [2*W-1:0] data_q, data_d;
    logic           valid_q, valid_d;
`ifdef UPSIZING_TLAST_EN
    logic [1:0]     keep_q, keep_d;
    logic           last_q, last_d;
`endif

    logic out_space;
    logic beat_last;
    logic accept;

    always_comb begin
        beat_last = 1'b0;
`ifdef UPSIZING_TLAST_EN
        beat_last = in_tlast;
`endif
        out_space = ~valid_q | out_tready;
        // A lone last beat in PH_UPPER goes straight to the output register, so it needs space.
        if (phase_q == PH_UPPER) begin
            in_tready = beat_last ? out_space : 1'b1;
        end else begin
            in_tready = out_space;
        end
        accept = in_tvalid & in_tready;
    end

    always_comb begin
        phase_d = phase_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q & ~out_tready;
`ifdef UPSIZING_TLAST_EN
        keep_d  = keep_q;
        last_d  = last_q;
`endif
        if (accept) begin
            unique case (phase_q)
                PH_UPPER: begin
                    if (beat_last) begin
                        data_d  = {in_tdata, {W{1'b0}}};
                        valid_d = 1'b1;
`ifdef UPSIZING_TLAST_EN
                        keep_d  = KEEP_UPPER;
                        last_d  = 1'b1;
`endif
                    end else begin
                        hold_d  = in_tdata;
                        phase_d = PH_LOWER;
                    end
                end
                PH_LOWER: begin
                    data_d  = {hold_q, in_tdata};
                    valid_d = 1'b1;
                    phase_d = PH_UPPER;
`ifdef UPSIZING_TLAST_EN
                    keep_d  = KEEP_FULL;
                    last_d  = beat_last;
`endif
                end
                default: phase_d = PH_UPPER;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q <= PH_UPPER;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef UPSIZING_TLAST_EN
            keep_q  <= 2'b00;
            last_q  <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef UPSIZING_TLAST_EN
            keep_q  <= keep_d;
            last_q  <= last_d;
`endif
        end
    end

    assign out_tdata  = data_q;
    assign out_tvalid = valid_q;
`ifdef UPSIZING_TLAST_EN
    assign out_tkeep  = keep_q;
    assign out_tlast  = last_q;
`endif

endmodule

// File: tb/tb_upsizing.sv
// Scoreboard bench for upsizing with W = 8; framing cases run when UPSIZING_TLAST_EN is defined.
module tb_upsizing;

    localparam int unsigned W = 8;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } exp_t;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic [15:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
`ifdef UPSIZING_TLAST_EN
    logic        in_tlast;
    logic [1:0]  out_tkeep;
    logic        out_tlast;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t exp_q[$];
    int   out_cycles[$];

    upsizing #(.W(W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
`ifdef UPSIZING_TLAST_EN
        .in_tlast  (in_tlast),
        .out_tkeep (out_tkeep),
        .out_tlast (out_tlast),
`endif
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every output handshake pops one expected word.
    always @(negedge aclk) begin
        if (aresetn && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", out_tdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_tdata", {16'h0, out_tdata}, {16'h0, e.data});
`ifdef UPSIZING_TLAST_EN
                chk("out_tkeep", {30'h0, out_tkeep}, {30'h0, e.keep});
                chk("out_tlast", {31'h0, out_tlast}, {31'h0, e.last});
`endif
                out_cycles.push_back(cyc);
            end
        end
    end

    // Offers one beat; returns the number of cycles it waited on in_tready.
    task automatic send_beat(input logic [7:0] d, input logic l, output int stalls);
        stalls    = 0;
        in_tdata  = d;
        in_tvalid = 1'b1;
`ifdef UPSIZING_TLAST_EN
        in_tlast  = l;
`endif
        forever begin
            @(negedge aclk);
            if (in_tready) break;
            stalls++;
            if (stalls > 50) begin
                $display("FAIL send_timeout: beat %0h not accepted, expected acceptance", d);
                errors++;
                checks++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "handshake timeout");
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        in_tvalid = 1'b0;
`ifdef UPSIZING_TLAST_EN
        in_tlast  = 1'b0;
`endif
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge aclk);
            n++;
        end
        @(posedge aclk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int st;
        int total;
        aresetn    = 1'b0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
`ifdef UPSIZING_TLAST_EN
        in_tlast   = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_out_tvalid", {31'h0, out_tvalid}, 32'h0);
        chk("rst_out_tdata", {16'h0, out_tdata}, 32'h0);
        chk("rst_in_tready", {31'h0, in_tready}, 32'h1);
`ifdef UPSIZING_TLAST_EN
        chk("rst_out_tkeep", {30'h0, out_tkeep}, 32'h0);
        chk("rst_out_tlast", {31'h0, out_tlast}, 32'h0);
`endif
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // Single pair, one-cycle latency, no backpressure.
        push(16'hAABB, 2'b11, 1'b0);
        send_beat(8'hAA, 1'b0, st);
        chk("pair_stall_aa", st, 0);
        send_beat(8'hBB, 1'b0, st);
        chk("pair_stall_bb", st, 0);
        idle();
        @(negedge aclk);
        chk("pair_latency_valid", {31'h0, out_tvalid}, 32'h1);
        drain("pair_drained");

        // Back-to-back stream: one word every two cycles.
        out_cycles.delete();
        push(16'h0102, 2'b11, 1'b0);
        push(16'h0304, 2'b11, 1'b0);
        push(16'h0506, 2'b11, 1'b0);
        push(16'h0708, 2'b11, 1'b0);
        total = 0;
        for (int i = 1; i <= 8; i++) begin
            send_beat(i[7:0], 1'b0, st);
            total += st;
        end
        idle();
        chk("stream_no_stall", total, 0);
        drain("stream_drained");
        chk("stream_word_count", out_cycles.size(), 4);
        if (out_cycles.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("stream_spacing", out_cycles[i] - out_cycles[i-1], 2);
            end
        end

        // Stall: first beat still accepted, second held off until the output drains.
        out_tready = 1'b0;
        push(16'h1122, 2'b11, 1'b0);
        push(16'h3344, 2'b11, 1'b0);
        send_beat(8'h11, 1'b0, st);
        send_beat(8'h22, 1'b0, st);
        send_beat(8'h33, 1'b0, st);
        chk("stall_first_beat_accepted", st, 0);
        in_tdata = 8'h44;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("stall_in_tready", {31'h0, in_tready}, 32'h0);
            chk("stall_out_tdata", {16'h0, out_tdata}, 32'h1122);
        end
        @(posedge aclk);
        #1;
        out_tready = 1'b1;
        send_beat(8'h44, 1'b0, st);
        idle();
        drain("stall_drained");

        // Reset with a held upper half: it must never surface.
        send_beat(8'h55, 1'b0, st);
        idle();
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", {31'h0, out_tvalid}, 32'h0);
        chk("async_rst_tdata", {16'h0, out_tdata}, 32'h0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        push(16'h6677, 2'b11, 1'b0);
        send_beat(8'h66, 1'b0, st);
        chk("post_rst_first_accept", st, 0);
        send_beat(8'h77, 1'b0, st);
        idle();
        drain("reset_drained");

`ifdef UPSIZING_TLAST_EN
        // Odd-length packet ends with a half word.
        push(16'hA1A2, 2'b11, 1'b0);
        push(16'hA300, 2'b10, 1'b1);
        send_beat(8'hA1, 1'b0, st);
        send_beat(8'hA2, 1'b0, st);
        send_beat(8'hA3, 1'b1, st);
        idle();
        drain("odd_pkt_drained");

        // Even-length packet ends with a full word.
        push(16'hC1C2, 2'b11, 1'b1);
        send_beat(8'hC1, 1'b0, st);
        send_beat(8'hC2, 1'b1, st);
        idle();
        drain("even_pkt_drained");
`endif

        repeat (4) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
